// File: rtl/parity_frame_serializer.sv
// parity_frame_serializer
// Takes a parallel word on a valid/ready handshake and streams it out one bit
// per clock, followed by a parity bit, with sof/eof framing strobes and an
// optional idle gap before the next word is accepted.
module parity_frame_serializer #(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_ODD = 0,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              sof,
  output logic              eof,
  output logic              busy
);

  localparam int              CW       = $clog2(DATA_W);
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);
  // GAP is unreachable when GAP_CYCLES is 0, so the value used there is moot
  localparam logic [3:0]      LAST_GAP = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam logic            ODD      = (PARITY_ODD != 0);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic [3:0]        gap_cnt;
  logic              par;

  // Handshake and activity flags are pure state decodes
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Frame sequencer: the shift register always holds the bit currently on
  // ser_out at its output end, so the next bit is one position further in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      gap_cnt   <= '0;
      par       <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          sof       <= 1'b0;
          eof       <= 1'b0;
          if (in_valid) begin
            state     <= SHIFT;
            shreg     <= in_data;
            par       <= (^in_data) ^ ODD;
            cnt       <= '0;
            ser_out   <= (MSB_FIRST != 0) ? in_data[DATA_W-1] : in_data[0];
            ser_valid <= 1'b1;
            sof       <= 1'b1;
          end
        end
        SHIFT: begin
          sof <= 1'b0;
          if (cnt == LAST_BIT) begin
            state   <= PARITY;
            ser_out <= par;
            eof     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (MSB_FIRST != 0) begin
              ser_out <= shreg[DATA_W-2];
              shreg   <= {shreg[DATA_W-2:0], 1'b0};
            end else begin
              ser_out <= shreg[1];
              shreg   <= {1'b0, shreg[DATA_W-1:1]};
            end
          end
        end
        PARITY: begin
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          eof       <= 1'b0;
          gap_cnt   <= '0;
          state     <= (GAP_CYCLES == 0) ? IDLE : GAP;
        end
        GAP: begin
          if (gap_cnt == LAST_GAP) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
